// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master Wishbone round-robin arbiter onto one shared slave
// Optional bus timeout compiled in with `define ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_D = 2'b01,
    GNT_I = 2'b10
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;  // 1: m1 was granted last
  logic [7:0]  cnt_q, cnt_d;

  logic        req0, req1;
  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_addr, g_data;
  logic        g_is_m1;
  logic        at_limit;
  logic        timeout_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign g_is_m1 = (state_q == GNT_I);
  assign g_cyc   = g_is_m1 ? m1_cyc_i  : m0_cyc_i;
  assign g_stb   = g_is_m1 ? m1_stb_i  : m0_stb_i;
  assign g_we    = g_is_m1 ? m1_we_i   : m0_we_i;
  assign g_sel   = g_is_m1 ? m1_sel_i  : m0_sel_i;
  assign g_addr  = g_is_m1 ? m1_addr_i : m0_addr_i;
  assign g_data  = g_is_m1 ? m1_data_i : m0_data_i;

  assign at_limit = (cnt_q == TO_LAST);

`ifdef ARB_TIMEOUT_EN
  // A coinciding ack always beats the timeout.
  assign timeout_hit = at_limit & g_cyc & g_stb & ~s_ack_i;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_addr_o   = '0;
    s_data_o   = '0;
    m0_data_o  = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_data_o  = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && (!req1 || last_gnt_q)) begin
          state_d = GNT_D;
        end else if (req1) begin
          state_d = GNT_I;
        end
      end

      GNT_D, GNT_I: begin
        s_cyc_o  = g_cyc & ~timeout_hit;
        s_stb_o  = g_stb & ~timeout_hit;
        s_we_o   = g_we;
        s_sel_o  = g_sel;
        s_addr_o = g_addr;
        s_data_o = g_data;
        if (g_is_m1) begin
          m1_ack_o  = s_ack_i;
          m1_data_o = s_data_i;
          m1_err_o  = timeout_hit;
        end else begin
          m0_ack_o  = s_ack_i;
          m0_data_o = s_data_i;
          m0_err_o  = timeout_hit;
        end

        // Grant is kept for the whole cycle; dropping cyc or a timeout ends it.
        if (!g_cyc || timeout_hit) begin
          state_d    = IDLE;
          last_gnt_d = g_is_m1;
          cnt_d      = '0;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (g_stb && !at_limit) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_o = state_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb/tb_wb_master_arbiter.sv - randomized and directed bench for wb_master_arbiter
module tb_wb_master_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  wire [70:0]  s_bus   = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o};
  wire [33:0]  m0_resp = {m0_data_o, m0_ack_o, m0_err_o};
  wire [33:0]  m1_resp = {m1_data_o, m1_ack_o, m1_err_o};
  wire [140:0] all_out = {s_bus, gnt_o, m0_resp, m1_resp};

  wb_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wd[0]),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wd[1]),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_rdata), .s_ack_i(s_ack), .gnt_o(gnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner 0 = nobody, 1 = m0, 2 = m1; last = index of last owner.
  int mdl_owner, mdl_last, mdl_cnt;
  logic [70:0] exp_s_bus;
  logic [33:0] exp_resp[2];
  logic [1:0]  exp_gnt;

  function automatic bit mdl_timeout();
`ifdef ARB_TIMEOUT_EN
    int g;
    if (mdl_owner == 0) return 1'b0;
    g = mdl_owner - 1;
    return m_cyc[g] && m_stb[g] && !s_ack && (mdl_cnt == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_eval();
    int g;
    bit tmo;
    exp_s_bus   = '0;
    exp_resp[0] = '0;
    exp_resp[1] = '0;
    exp_gnt     = 2'b00;
    if (rst && mdl_owner != 0) begin
      g   = mdl_owner - 1;
      tmo = mdl_timeout();
      exp_gnt     = 2'(mdl_owner);
      exp_s_bus   = {m_cyc[g] & !tmo, m_stb[g] & !tmo, m_we[g], m_sel[g], m_addr[g], m_wd[g]};
      exp_resp[g] = {s_rdata, s_ack, tmo};
    end
  endtask

  task automatic model_clock();
    int g;
    bit r0, r1;
    if (!rst) begin
      mdl_owner = 0; mdl_last = 1; mdl_cnt = 0;
    end else if (mdl_owner == 0) begin
      r0 = m_cyc[0] && m_stb[0];
      r1 = m_cyc[1] && m_stb[1];
      if (r0 && r1) mdl_owner = (mdl_last == 1) ? 1 : 2;
      else if (r0)  mdl_owner = 1;
      else if (r1)  mdl_owner = 2;
      mdl_cnt = 0;
    end else begin
      g = mdl_owner - 1;
      if (!m_cyc[g] || mdl_timeout()) begin
        mdl_owner = 0; mdl_last = g; mdl_cnt = 0;
      end else if (s_ack) begin
        mdl_cnt = 0;
      end else if (m_stb[g] && mdl_cnt < TO - 1) begin
        mdl_cnt = mdl_cnt + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic quiet_inputs();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
      m_sel[k] = '0; m_addr[k] = '0; m_wd[k] = '0;
    end
    s_ack = 1'b0; s_rdata = '0;
  endtask

  task automatic idle_all();
    quiet_inputs();
    step();
    step();
  endtask

  task automatic request(input int k, input bit we, input logic [31:0] addr);
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
    m_sel[k] = 4'hF; m_addr[k] = addr; m_wd[k] = $urandom;
  endtask

  task automatic release_m(input int k);
    m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    request(0, 1'b1, $urandom);
    request(1, 1'b0, $urandom);
    s_ack = 1'b1; s_rdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (all_out !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h, want 0", all_out);
      end
      step();
    end
    quiet_inputs();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b, want 00", gnt_o);
    end
  endtask

  task automatic test_single_read();
    idle_all();
    request(0, 1'b0, 32'h8000_0010);
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL read_gnt_c0: got %b, want 00", gnt_o); end
    step();
    for (int c = 1; c <= 3; c++) begin
      s_ack   = (c == 3);
      s_rdata = (c == 3) ? 32'hDEAD_BEEF : $urandom;
      @(negedge clk);
      vectors += 4;
      if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL read_gnt c%0d: got %b, want 01", c, gnt_o); end
      if (s_addr_o !== 32'h8000_0010) begin miscompares++; $display("FAIL read_addr c%0d: got %h, want 80000010", c, s_addr_o); end
      if (m1_ack_o !== 1'b0) begin miscompares++; $display("FAIL read_m1_ack c%0d: got %b, want 0", c, m1_ack_o); end
      if (c == 3) begin
        if ({m0_ack_o, m0_data_o} !== {1'b1, 32'hDEAD_BEEF}) begin
          miscompares++; $display("FAIL read_data: got ack %b data %h, want ack 1 data deadbeef", m0_ack_o, m0_data_o);
        end
      end else if (m0_ack_o !== 1'b0) begin
        miscompares++; $display("FAIL read_early_ack c%0d: got %b, want 0", c, m0_ack_o);
      end
      step();
    end
    release_m(0); s_ack = 1'b0;
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL read_end_gnt: got %b, want 00", gnt_o); end
  endtask

  task automatic test_tie();
    quiet_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    request(0, 1'b0, $urandom);
    request(1, 1'b0, $urandom);
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL tie_c0: got %b, want 00", gnt_o); end
    step();
    s_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL tie_first: got %b, want 01", gnt_o); end
    step();
    release_m(0); s_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if ({gnt_o, s_cyc_o} !== 3'b010) begin miscompares++; $display("FAIL tie_abort: got gnt %b cyc %b, want 01 0", gnt_o, s_cyc_o); end
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL tie_turn: got %b, want 00", gnt_o); end
    step();
    request(0, 1'b0, $urandom);
    s_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gnt_o, m0_ack_o} !== 3'b100) begin miscompares++; $display("FAIL tie_second: got gnt %b m0_ack %b, want 10 0", gnt_o, m0_ack_o); end
    step();
    release_m(1); s_ack = 1'b0;
    step();
    request(1, 1'b0, $urandom);
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL tie2_idle: got %b, want 00", gnt_o); end
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL tie2_rr: got %b, want 01", gnt_o); end
  endtask

  task automatic test_burst();
    int acks = 0;
    idle_all();
    request(1, 1'b0, 32'h0);
    step();
    request(0, 1'b1, $urandom);
    for (int b = 0; b < 4; b++) begin
      m_addr[1] = 32'(b * 4);
      s_ack = 1'b1; s_rdata = $urandom;
      @(negedge clk);
      if (m1_ack_o === 1'b1) acks++;
      vectors += 2;
      if ({gnt_o, s_addr_o} !== {2'b10, 32'(b * 4)}) begin
        miscompares++; $display("FAIL burst_beat%0d: got gnt %b addr %h, want 10 %h", b, gnt_o, s_addr_o, b * 4);
      end
      if (m0_ack_o !== 1'b0) begin miscompares++; $display("FAIL burst_m0_held%0d: got %b, want 0", b, m0_ack_o); end
      step();
    end
    release_m(1); s_ack = 1'b0;
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL burst_idle: got %b, want 00", gnt_o); end
    step();
    @(negedge clk);
    vectors++;
    if ({gnt_o, 3'(acks)} !== {2'b01, 3'd4}) begin
      miscompares++; $display("FAIL burst_handover: got gnt %b acks %0d, want 01 4", gnt_o, acks);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    idle_all();
    request(0, 1'b1, $urandom);
    step();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (m0_err_o === 1'b1) pulses++;
      vectors++;
      if ({m0_err_o, s_cyc_o} !== ((c == TO) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL timeout_c%0d: got err %b cyc %b", c, m0_err_o, s_cyc_o);
      end
      step();
    end
    release_m(0);
    @(negedge clk);
    vectors++;
    if ({gnt_o, 4'(pulses)} !== {2'b00, 4'd1}) begin
      miscompares++; $display("FAIL timeout_end: got gnt %b pulses %0d, want 00 1", gnt_o, pulses);
    end
    idle_all();
    request(0, 1'b0, $urandom);
    step();
    for (int c = 1; c <= TO; c++) begin
      s_ack = (c == TO);
      @(negedge clk);
      vectors++;
      if ({m0_err_o, m0_ack_o} !== {1'b0, s_ack}) begin
        miscompares++; $display("FAIL ack_wins_c%0d: got err %b ack %b", c, m0_err_o, m0_ack_o);
      end
      step();
    end
  endtask
`else
  task automatic test_long_stall();
    int errs = 0;
    idle_all();
    request(0, 1'b0, $urandom);
    step();
    for (int c = 1; c <= 300; c++) begin
      s_ack = (c == 300);
      s_rdata = $urandom;
      @(negedge clk);
      if (m0_err_o !== 1'b0) errs++;
      vectors++;
      if (m0_ack_o !== (c == 300)) begin
        miscompares++; $display("FAIL stall_ack_c%0d: got %b, want %b", c, m0_ack_o, c == 300);
      end
      step();
    end
    vectors++;
    if (errs != 0) begin miscompares++; $display("FAIL stall_err: got %0d err cycles, want 0", errs); end
  endtask
`endif

  task automatic test_reset_mid();
    idle_all();
    request(1, 1'b0, $urandom);
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b10) begin miscompares++; $display("FAIL rstmid_gnt: got %b, want 10", gnt_o); end
    #1 rst = 1'b0;
    s_ack = 1'b1;
    #1;
    vectors++;
    if (all_out !== '0) begin miscompares++; $display("FAIL rstmid_outputs: got %h, want 0", all_out); end
    step();
    rst = 1'b1; s_ack = 1'b0;
    request(0, 1'b0, $urandom);
    request(1, 1'b0, $urandom);
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL rstmid_tie: got %b, want 01", gnt_o); end
  endtask

  task automatic test_random(input int n);
    idle_all();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_cyc[k]) begin
          if ($urandom_range(0, 3) == 0) request(k, 1'($urandom), $urandom);
        end else if ($urandom_range(0, 5) == 0) begin
          release_m(k);
        end else begin
          m_stb[k]  = ($urandom_range(0, 3) != 0);
          m_addr[k] = $urandom; m_wd[k] = $urandom; m_sel[k] = 4'($urandom);
        end
      end
      s_ack = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      model_eval();
      vectors += 4;
      if (s_bus !== exp_s_bus) begin miscompares++; $display("FAIL rnd_slave %0d: got %h, want %h", i, s_bus, exp_s_bus); end
      if (gnt_o !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt %0d: got %b, want %b", i, gnt_o, exp_gnt); end
      if (m0_resp !== exp_resp[0]) begin miscompares++; $display("FAIL rnd_m0 %0d: got %h, want %h", i, m0_resp, exp_resp[0]); end
      if (m1_resp !== exp_resp[1]) begin miscompares++; $display("FAIL rnd_m1 %0d: got %h, want %h", i, m1_resp, exp_resp[1]); end
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    quiet_inputs();
    mdl_owner = 0; mdl_last = 1; mdl_cnt = 0;
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_reset_mid();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, number of stalled strobe cycles before the arbiter aborts a transfer; legal range 2..255.
REQ-002 clk  input  1  single clock for all state; every register samples on the rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low; when low, all state is forced to reset values at once.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  data-master Wishbone cycle, strobe and write enable.
REQ-005 m0_sel_i  input  4, m0_addr_i  input  32, m0_data_i  input  32  data-master byte select, address and write data.
REQ-006 m0_data_o  output  32, m0_ack_o  output  1, m0_err_o  output  1  data-master read data, acknowledge and error.
REQ-007 m1_* ports  same directions and widths as REQ-004..REQ-006  instruction-fetch master.
REQ-008 s_cyc_o, s_stb_o, s_we_o  output  1, s_sel_o  output  4, s_addr_o, s_data_o  output  32  shared slave-side request.
REQ-009 s_data_i  input  32, s_ack_i  input  1  shared slave-side read data and acknowledge.
REQ-010 gnt_o  output  2  current grant: 00 idle, 01 m0, 10 m1.

Function
REQ-011 States: IDLE, GNT_D (m0 granted), GNT_I (m1 granted).
REQ-012 A master is requesting when its cyc_i and stb_i are both high.
REQ-013 IDLE, one master requesting: move to that master's grant state at the next edge; arbitration latency is 1 cycle.
REQ-014 IDLE, both masters requesting: grant the master that was not granted last (round-robin via the last_gnt register).
REQ-015 IDLE, no master requesting: remain in IDLE.
REQ-016 In a grant state, s_cyc/stb/we/sel/addr/data_o follow the granted master combinationally, with zero latency.
REQ-017 In a grant state, the granted master's ack_o equals s_ack_i, and its data_o equals s_data_i.
REQ-018 The ungranted master's ack_o and err_o are held at 0, and its data_o is held at 0.
REQ-019 In IDLE, all s_* outputs, all ack_o/err_o and all data_o are 0.
REQ-020 Grant is held for as long as the granted master's cyc_i is high, so multi-beat cycles are never split.
REQ-021 When the granted master's cyc_i is low at an edge, the arbiter returns to IDLE and last_gnt records that master.
REQ-022 When cyc_i drops mid-transfer, s_cyc_o drops in the same cycle (abort) and the arbiter returns to IDLE at the next edge.
REQ-023 A request from the ungranted master is held off with no ack until it is granted; it is never dropped.
REQ-024 On return to IDLE with the other master waiting, that master is granted on the following edge; minimum turnaround is 2 cycles.

Reset
REQ-025 During reset: state is IDLE, last_gnt is m1 (so m0 wins the first tie), the timeout counter is 0, and gnt_o is 00.
REQ-026 During reset, all outputs are 0.
REQ-027 Reset asserted mid-transfer immediately drops s_cyc_o/s_stb_o; no ack or err is delivered to either master.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN compiles in the bus timeout; without the macro, m0_err_o and m1_err_o are tied to 0 and the arbiter waits indefinitely for s_ack_i.
REQ-029 With ARB_TIMEOUT_EN, an 8-bit counter clears on grant and on every s_ack_i.
REQ-030 With ARB_TIMEOUT_EN, the counter increments each cycle that s_stb_o is high and s_ack_i is low.
REQ-031 With ARB_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES-1 and s_ack_i is low: the granted master's err_o pulses for 1 cycle, s_cyc_o/s_stb_o are forced low that cycle, and the arbiter returns to IDLE.
REQ-032 With ARB_TIMEOUT_EN, if s_ack_i and the timeout coincide, the ack wins and err_o stays 0.

Verification
REQ-033 m0 only requests read addr 0x8000_0010, slave acks after 3 cycles with 0xDEAD_BEEF -> gnt_o=01 at cycle 1, m0_data_o=0xDEAD_BEEF with m0_ack_o=1, m1_ack_o=0 throughout.
REQ-034 m0 and m1 request in the same cycle after reset -> m0 is granted first; after m0 drops cyc, m1 is granted 2 cycles later; a second tie then goes to m0.
REQ-035 m1 holds cyc for 4 beats (sel=1111, addr 0x0,0x4,0x8,0xC) while m0 requests -> all 4 m1 beats complete before gnt_o becomes 01.
REQ-036 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks an m0 write -> m0_err_o pulses exactly once at the 16th stalled cycle, s_cyc_o=0 that cycle, gnt_o=00 next cycle.
REQ-037 rst driven low during an m1 read with ack pending -> all outputs are 0 immediately, and after release the first tie is granted to m0.
REQ-038 Without ARB_TIMEOUT_EN, slave stalls 300 cycles then acks -> no err, transfer completes with m0_ack_o=1 on cycle 300.
